cdc_handshake_tx: RTL and testbench
===================================

# cdc_handshake_tx

Source-domain transmitter for a two-phase (toggle) request/acknowledge clock-domain crossing. Accepts a data word on a valid/ready interface, holds it stable on the crossing bus, toggles a request line, and waits until the destination's toggled acknowledge returns through a local synchronizer before accepting the next word. It pairs with a destination-side receiver that synchronizes `xreq` and samples `xdat`. A watchdog flags acknowledges that never arrive.

## Interface
- N, 8: data width in bits
- D, 2: synchronizer stages on the returning `xack` (≥2)
- T, 1024: watchdog limit in `sclk` cycles spent waiting for acknowledge (≥1)

- sclk  in  1  source core clock; all logic is on the rising edge
- srstn  in  1  source core reset; asynchronous, active-low
- s_valid  in  1  upstream word valid
- s_ready  out  1  block can accept a word this cycle
- s_data  in  N  upstream word
- xreq  out  1  request toggle to the destination domain (registered)
- xdat  out  N  crossing data; registered; stable whenever `xreq` ≠ synchronized `xack`
- xack  in  1  acknowledge toggle from the destination domain (asynchronous to `sclk`)
- busy  out  1  transfer outstanding (state WAIT)
- serr  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, WAIT.
  - IDLE: `s_ready`=1. On `s_valid`=1: `xdat`<=`s_data`, `xreq`<=~`xreq`, `wcnt`<=0, go to WAIT.
  - WAIT: `s_ready`=0, `busy`=1. `ack_s` = `xack` after D flops. When `ack_s`==`xreq`: go to IDLE. Otherwise `wcnt` increments, saturating at T.
- `xdat` and `xreq` load only on an accepted word (IDLE and `s_valid`). They never change in WAIT.
- `s_data` is ignored when `s_ready`=0.
- Watchdog: when `wcnt` reaches T while in WAIT, `serr`<=1. `serr` stays set until reset. The FSM keeps waiting; the block does not abort or re-toggle.
- No combinational path from `s_valid` to `s_ready`, or from `xack` to any output.
- Reset values: state IDLE, `s_ready`=1, `busy`=0, `xreq`=0, `xdat`=0, `serr`=0, `wcnt`=0, all `ack_s` stages 0.
- Reset mid-transfer drops the word and returns to IDLE with `xreq`=0. The destination must be reset in the same event so that toggle parity stays matched. This is a system requirement, not checked here.

## Timing
- Accept at edge k: `xreq` and `xdat` update after edge k. `busy`=1 and `s_ready`=0 from k until return to IDLE.
- Acknowledge return: if `xack` toggles before edge m, `ack_s` matches `xreq` after edge m+D-1. The FSM enters IDLE at edge m+D, and `s_ready`=1 after that edge.
- Minimum spacing between accepts is D+2 cycles when `xack` toggles in the cycle after `xreq`. Throughput is bounded by the round trip.
- `xack` toggling while in IDLE (spurious) matches `xreq` parity only after a toggle, which is a protocol violation. Behaviour on violation is undefined beyond never corrupting `xdat` mid-WAIT.
- Watchdog: `serr` rises at the edge where `wcnt` reaches T, that is, T cycles after the accept edge if no acknowledge arrives. It does not rise if the acknowledge is detected at the same edge.

## Structure
- Shared package `cdc_pkg`: FSM state enum (IDLE, WAIT) and the `wcnt` width function, $clog2(T+1).
- One sub-module: the team's `xNStageSynchronizer` with N=1, D=D, clocked by `sclk` and reset by `srstn`, on `xack`.
- Remainder: one FSM process plus the datapath registers `xdat`, `xreq`, `wcnt` and `serr`.

## Test plan
- Reset with `s_valid`=1 held: check `s_ready`=1, `xreq`=0, `xdat`=0, `serr`=0. After release, check that 0xA5 is accepted at the first edge and `xreq`=1.
- Single transfer of 0x3C, with a bench responder toggling `xack` 1 cycle after seeing `xreq`: `xdat`=0x3C is held through WAIT, and `s_ready` returns exactly D+1 cycles after the `xack` toggle edge.
- Back-to-back `s_valid` with words 0x01, 0x02, 0x03: each word is accepted only after its acknowledge, `xreq` toggles 3 times to end at 1, and no word is lost or duplicated.
- `s_data` changed every cycle during WAIT: `xdat` is unchanged until the next accept.
- No acknowledge, with T=16: `serr`=1 exactly 16 cycles after the accept edge. A late `xack` then returns the FSM to IDLE while `serr` stays 1.
- Assert `srstn` low mid-WAIT: outputs immediately (asynchronously) take their reset values. After release, a new transfer of 0x7E completes normally with the reset responder.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake CDC transmitter: FSM states and
// the watchdog counter width rule.
package cdc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Counter must be able to hold the value T itself.
    function automatic int cnt_width(input int t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/xNStageSynchronizer.sv
// Plain D-stage flop chain for bringing an asynchronous N-bit signal into the
// local clock domain; all stages clear on reset.
module xNStageSynchronizer #(
    parameter int N = 1,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] sync_q [D];
    logic [N-1:0] sync_d [D];

    // Shift the input one stage deeper each cycle.
    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < D; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < D; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q = sync_q[D-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a two-phase req/ack crossing: captures one word, toggles xreq,
// then waits for the synchronized xack to match before taking the next word.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 2,
    parameter int T = 1024
) (
    input  logic         sclk,
    input  logic         srstn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_data,
    output logic         xreq,
    output logic [N-1:0] xdat,
    input  logic         xack,
    output logic         busy,
    output logic         serr
);

    localparam int             W     = cnt_width(T);
    localparam logic [W-1:0]   T_CNT = W'(T);

    state_e       state_q, state_d;
    logic         xreq_q, xreq_d;
    logic [N-1:0] xdat_q, xdat_d;
    logic [W-1:0] wcnt_q, wcnt_d;
    logic         serr_q, serr_d;
    logic         ack_s;

    xNStageSynchronizer #(
        .N (1),
        .D (D)
    ) u_ack_sync (
        .clk   (sclk),
        .rst_n (srstn),
        .d     (xack),
        .q     (ack_s)
    );

    // Next-state and datapath: bus only loads on an accepted word.
    always_comb begin
        state_d = state_q;
        xreq_d  = xreq_q;
        xdat_d  = xdat_q;
        wcnt_d  = wcnt_q;
        serr_d  = serr_q;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    xdat_d  = s_data;
                    xreq_d  = ~xreq_q;
                    wcnt_d  = '0;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (ack_s == xreq_q) begin
                    state_d = IDLE;
                end else begin
                    if (wcnt_q != T_CNT) begin
                        wcnt_d = wcnt_q + W'(1);
                    end else begin
                        wcnt_d = wcnt_q;
                    end
                    // Sticky: raised when the count lands on T, never cleared here.
                    if (wcnt_d == T_CNT) begin
                        serr_d = 1'b1;
                    end else begin
                        serr_d = serr_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge sclk or negedge srstn) begin
        if (!srstn) begin
            state_q <= IDLE;
            xreq_q  <= 1'b0;
            xdat_q  <= '0;
            wcnt_q  <= '0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xreq_q  <= xreq_d;
            xdat_q  <= xdat_d;
            wcnt_q  <= wcnt_d;
            serr_q  <= serr_d;
        end
    end

    assign s_ready = (state_q == IDLE);
    assign busy    = (state_q == WAIT);
    assign xreq    = xreq_q;
    assign xdat    = xdat_q;
    assign serr    = serr_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Scoreboard bench for cdc_handshake_tx: words are queued on acceptance and a
// monitor checks them against xdat each time xreq toggles.
module tb_cdc_handshake_tx;

    localparam int N = 8;
    localparam int D = 2;
    localparam int T = 16;

    logic         sclk = 1'b0;
    logic         srstn;
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_data;
    logic         xreq;
    logic [N-1:0] xdat;
    logic         xack;
    logic         busy;
    logic         serr;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int acc_cyc   = 0;
    int ack_cyc   = 0;
    int acc_cnt   = 0;
    int resp_dly  = 1;
    bit resp_en   = 1'b0;
    bit ack_pending = 1'b0;
    bit serr_exp  = 1'b0;

    logic [N-1:0] exp_q [$];
    logic [N-1:0] mon_e;
    logic         prev_xreq  = 1'b0;
    logic         prev_ready = 1'b1;
    logic [N-1:0] prev_xdat  = '0;

    cdc_handshake_tx #(.N(N), .D(D), .T(T)) dut (
        .sclk    (sclk),
        .srstn   (srstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .xreq    (xreq),
        .xdat    (xdat),
        .xack    (xack),
        .busy    (busy),
        .serr    (serr)
    );

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: each xreq toggle presents one word; xdat must hold while busy.
    always @(negedge sclk) begin
        if (srstn) begin
            if (xreq != prev_xreq) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xreq_toggle", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("xdat_word", int'(xdat), int'(mon_e));
                end
                chk("xreq_parity", int'(xreq), acc_cnt % 2);
            end else if (busy) begin
                chk("xdat_hold", int'(xdat), int'(prev_xdat));
            end
            if (s_ready && !prev_ready && ack_pending) begin
                chk("ack_to_ready_latency", cyc - ack_cyc, D + 1);
                chk("serr_level", int'(serr), int'(serr_exp));
                ack_pending = 1'b0;
            end
        end
        prev_xreq  = xreq;
        prev_ready = s_ready;
        prev_xdat  = xdat;
    end

    // Destination stand-in: toggles xack resp_dly cycles after seeing a new xreq.
    initial begin
        xack = 1'b0;
        forever begin
            @(posedge sclk);
            #1;
            if (resp_en && srstn && (xreq != xack)) begin
                repeat (resp_dly) @(posedge sclk);
                #1;
                if (resp_en && srstn) begin
                    xack = ~xack;
                    ack_cyc = cyc;
                    ack_pending = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [N-1:0] w);
        int n = 0;
        @(negedge sclk);
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            s_data = N'($urandom);
            @(negedge sclk);
            n++;
        end
        if (!s_ready) begin
            chk("send_timeout", 0, 1);
        end else begin
            s_data = w;
            exp_q.push_back(w);
            acc_cnt++;
            @(posedge sclk);
            #1;
            acc_cyc = cyc;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge sclk);
        s_valid = 1'b0;
        while (!s_ready && n < 100) begin
            s_data = N'($urandom);
            @(negedge sclk);
            n++;
        end
        if (!s_ready) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        srstn   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        resp_en = 1'b1;
        resp_dly = 1;
        repeat (2) @(posedge sclk);
        #1;
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_xreq", int'(xreq), 0);
        chk("rst_xdat", int'(xdat), 0);
        chk("rst_serr", int'(serr), 0);
        chk("rst_busy", int'(busy), 0);
        #2;
        exp_q.push_back(8'hA5);
        acc_cnt = 1;
        srstn = 1'b1;
        @(posedge sclk);
        #1;
        chk("first_accept_xreq", int'(xreq), 1);
        chk("first_accept_xdat", int'(xdat), 32'hA5);
        wait_idle();

        send(8'h3C);
        wait_idle();

        send(8'h01);
        send(8'h02);
        send(8'h03);
        wait_idle();
        chk("b2b_xreq_end", int'(xreq), 1);
        chk("b2b_all_seen", exp_q.size(), 0);

        for (int i = 0; i < 20; i++) begin
            resp_dly = $urandom_range(1, 4);
            send(N'($urandom));
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        chk("rand_all_seen", exp_q.size(), 0);
        resp_dly = 1;

        resp_en = 1'b0;
        send(8'h99);
        begin
            int n = 0;
            @(negedge sclk);
            s_valid = 1'b0;
            while (!serr && n < 40) begin
                @(negedge sclk);
                n++;
            end
        end
        chk("serr_rise_cycle", cyc - acc_cyc, T);
        serr_exp = 1'b1;
        resp_en = 1'b1;
        wait_idle();
        chk("serr_sticky", int'(serr), 1);

        resp_en = 1'b0;
        send(8'h55);
        repeat (3) @(posedge sclk);
        #3;
        srstn   = 1'b0;
        xack    = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("async_rst_s_ready", int'(s_ready), 1);
        chk("async_rst_xreq", int'(xreq), 0);
        chk("async_rst_xdat", int'(xdat), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_serr", int'(serr), 0);
        exp_q.delete();
        acc_cnt = 0;
        ack_pending = 1'b0;
        serr_exp = 1'b0;
        @(posedge sclk);
        #3;
        srstn = 1'b1;
        resp_en = 1'b1;
        send(8'h7E);
        wait_idle();
        chk("post_rst_xreq", int'(xreq), 1);
        chk("post_rst_xdat", int'(xdat), 32'h7E);
        chk("post_rst_all_seen", exp_q.size(), 0);

        repeat (5) @(posedge sclk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
